// File: rtl/morse_sequencer_if.sv
// Word-push handshake into the Morse sequencer FIFO.
interface morse_sequencer_if #(parameter int WIDTH = 10);
    logic             in_valid;
    logic [WIDTH-1:0] in_word;
    logic             in_ready;

    modport master (output in_valid, output in_word, input in_ready);
    modport slave  (input in_valid, input in_word, output in_ready);
endinterface

// File: rtl/morse_sequencer.sv
// Queues Morse words in a small FIFO and keys them out as a tone with unit timing
// derived from a (period+1)-cycle prescaler.
module morse_sequencer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CW    = 25
) (
    input  logic                       clk,
    input  logic                       reset,
    morse_sequencer_if.slave           bus,
    input  logic [CW-1:0]              period,
    output logic                       tone,
    output logic                       sym_dot,
    output logic                       sym_dash,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int NSYM = WIDTH / 2;
    localparam int IW   = $clog2(NSYM);

    typedef enum logic [2:0] {IDLE, LOAD, SYM, TONE, SPACE, WGAP} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idx;
    logic [1:0]       rem;
    logic [CW-1:0]    cnt;
    logic             tick;

    assign bus.in_ready = (level != LW'(DEPTH));
    assign do_push      = bus.in_valid && bus.in_ready;
    assign do_pop       = (state == IDLE) && (level != '0);
    assign tick         = (cnt >= period);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= bus.in_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Holding cnt at zero through SYM makes the first tone/space unit a full period+1 cycles.
    always_ff @(posedge clk) begin
        if (reset || state == SYM || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            rem      <= '0;
            tone     <= 1'b0;
            sym_dot  <= 1'b0;
            sym_dash <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sym_dot  <= 1'b0;
            sym_dash <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        shreg <= mem[rd_ptr];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: state <= SYM;
                SYM: begin
                    case (shreg[WIDTH-1 -: 2])
                        2'b10: begin
                            state   <= TONE;
                            rem     <= 2'd1;
                            tone    <= 1'b1;
                            sym_dot <= 1'b1;
                        end
                        2'b11: begin
                            state    <= TONE;
                            rem      <= 2'd3;
                            tone     <= 1'b1;
                            sym_dash <= 1'b1;
                        end
                        default: begin
                            state <= SPACE;
                            rem   <= 2'd2;
                        end
                    endcase
                end
                TONE: begin
                    if (tick) begin
                        if (rem == 2'd1) begin
                            state <= SPACE;
                            rem   <= 2'd1;
                            tone  <= 1'b0;
                        end else begin
                            rem <= rem - 2'd1;
                        end
                    end
                end
                SPACE: begin
                    if (tick) begin
                        if (rem == 2'd1) begin
                            shreg <= {shreg[WIDTH-3:0], 2'b00};
                            idx   <= idx + 1'b1;
                            if (idx == IW'(NSYM - 1)) begin
                                state <= WGAP;
                                rem   <= 2'd3;
                            end else begin
                                state <= SYM;
                            end
                        end else begin
                            rem <= rem - 2'd1;
                        end
                    end
                end
                WGAP: begin
                    if (tick) begin
                        if (rem == 2'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            rem <= rem - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench: a per-word unit timeline model predicts every output each cycle.
module tb_morse_sequencer;
    localparam int W = 10;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] period;
    logic        tone, sym_dot, sym_dash, busy, done;
    logic [2:0]  level;

    morse_sequencer_if #(.WIDTH(W)) bus ();

    morse_sequencer #(.WIDTH(W), .DEPTH(D), .CW(25)) dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus),
        .period   (period),
        .tone     (tone),
        .sym_dot  (sym_dot),
        .sym_dash (sym_dash),
        .busy     (busy),
        .done     (done),
        .level    (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: queued words, and the expected {tone,dot,dash} of each busy cycle still to come.
    logic [W-1:0] m_fifo[$];
    logic [2:0]   exp_q[$];
    logic         m_done = 1'b0;

    int  n_dot, n_dash, n_done, n_busy, n_acc, run;
    int  runs[$];
    logic prev_tone = 1'b0, prev_done = 1'b0, rise_dash = 1'b0, busy_after_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void expand(input logic [W-1:0] w, input int u);
        logic [1:0] sy;
        int ton, sil;
        exp_q.push_back(3'b000);
        for (int s = 0; s < W / 2; s++) begin
            sy  = w[W-1-2*s -: 2];
            ton = (sy == 2'b11) ? 3 * u : (sy == 2'b10) ? u : 0;
            sil = (ton != 0) ? u : 2 * u;
            exp_q.push_back(3'b000);
            for (int k = 0; k < ton; k++)
                exp_q.push_back(k != 0 ? 3'b100 : (sy == 2'b11 ? 3'b101 : 3'b110));
            for (int k = 0; k < sil; k++)
                exp_q.push_back(3'b000);
        end
        for (int k = 0; k < 3 * u; k++)
            exp_q.push_back(3'b000);
    endfunction

    task automatic cyc();
        logic idle, rdy;
        logic [2:0] e;
        logic [31:0] obs, exv;
        idle = (exp_q.size() == 0);
        rdy  = (m_fifo.size() != D);
        if (bus.in_valid && bus.in_ready && !rst)
            n_acc++;
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!idle) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0)
                    m_done = 1'b1;
            end else if (m_fifo.size() != 0) begin
                expand(m_fifo.pop_front(), int'(period) + 1);
            end
            if (bus.in_valid && rdy)
                m_fifo.push_back(bus.in_word);
        end
        @(posedge clk);
        #1;
        e   = (exp_q.size() != 0) ? exp_q[0] : 3'b000;
        exv = {23'd0, e, exp_q.size() != 0, m_done, 3'(m_fifo.size()), m_fifo.size() != D};
        obs = {23'd0, tone, sym_dot, sym_dash, busy, done, level, bus.in_ready};
        chk("cycle", obs, exv);
        if (tone && !prev_tone)
            rise_dash = sym_dash;
        if (prev_done)
            busy_after_done = busy;
        if (tone) run++;
        else if (run != 0) begin
            runs.push_back(run);
            run = 0;
        end
        n_dot  += int'(sym_dot);
        n_dash += int'(sym_dash);
        n_done += int'(done);
        n_busy += int'(busy);
        prev_tone = tone;
        prev_done = done;
    endtask

    task automatic clear_stats();
        n_dot = 0; n_dash = 0; n_done = 0; n_busy = 0; n_acc = 0; run = 0;
        runs.delete();
    endtask

    task automatic push_word(input logic [W-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_word  = logic'($urandom) ? '1 : '0;
    endtask

    task automatic wait_done(input int n, input int bound, input string tag);
        for (int i = 0; i < bound && n_done < n; i++)
            cyc();
        chk(tag, n_done, n);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5000 && (exp_q.size() != 0 || m_fifo.size() != 0 || m_done); i++)
            cyc();
        cyc();
        chk(tag, {busy, level}, 4'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        period = '0;
        clear_stats();
        cyc();
        cyc();
        chk("reset_state", {tone, sym_dot, sym_dash, busy, done, level, bus.in_ready}, 9'b00000_000_1);
        rst = 1'b0;
        cyc();

        // T1: dot, dash, three letter spaces at one cycle per unit
        clear_stats();
        push_word(10'b10_11_00_00_00);
        wait_done(1, 200, "t1_done");
        chk("t1_dots", n_dot, 1);
        chk("t1_dashes", n_dash, 1);
        chk("t1_runs", runs.size(), 2);
        chk("t1_run0", runs.size() > 0 ? runs[0] : -1, 1);
        chk("t1_run1", runs.size() > 1 ? runs[1] : -1, 3);
        for (int i = 0; i < 4; i++) cyc();

        // T2: a dash at five cycles per unit
        clear_stats();
        period = 25'd4;
        push_word(10'b11_00_00_00_00);
        wait_done(1, 500, "t2_done");
        chk("t2_runs", runs.size(), 1);
        chk("t2_run0", runs.size() > 0 ? runs[0] : -1, 15);
        chk("t2_dash_align", rise_dash, 1'b1);

        // T5: all letter spaces -> silent, LOAD + 5 SYM + 13 units busy
        clear_stats();
        period = '0;
        push_word('0);
        wait_done(1, 200, "t5_done");
        chk("t5_silent", runs.size(), 0);
        chk("t5_busy_len", n_busy, 19);

        // T6: two queued words play back to back
        clear_stats();
        push_word(10'b10_11_00_00_00);
        push_word(10'b10_11_00_00_00);
        wait_done(2, 400, "t6_done");
        chk("t6_load_after_done", busy_after_done, 1'b1);
        chk("t6_runs", runs.size(), 4);
        chk("t6_run2", runs.size() > 2 ? runs[2] : -1, 1);
        chk("t6_run3", runs.size() > 3 ? runs[3] : -1, 3);
        drain("t6_idle");

        // Randomized traffic at two unit lengths, including back-pressure
        for (int ph = 0; ph < 2; ph++) begin
            period = (ph == 0) ? 25'd1 : 25'd3;
            for (int i = 0; i < 300; i++) begin
                bus.in_valid = ($urandom_range(0, 9) < 3);
                bus.in_word  = W'($urandom);
                cyc();
            end
            bus.in_valid = 1'b0;
            drain("rand_drain");
        end

        // T3: six back-to-back offers against a long unit
        clear_stats();
        period = 25'd1000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_word = (i == 0) ? '0 : W'($urandom);
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("t3_accepted", n_acc, 5);
        chk("t3_full", {level, bus.in_ready}, {3'd4, 1'b0});
        for (int i = 0; i < 20000 && !bus.in_ready; i++)
            cyc();
        chk("t3_ready_back", {level, bus.in_ready}, {3'd3, 1'b1});
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // T4: reset in the middle of a dash
        clear_stats();
        period = 25'd2;
        push_word('1);
        for (int i = 0; i < 100 && n_dash == 0; i++)
            cyc();
        chk("t4_dash_seen", n_dash, 1);
        for (int i = 0; i < 3; i++) cyc();
        chk("t4_tone_on", tone, 1'b1);
        rst = 1'b1;
        cyc();
        chk("t4_after_reset", {tone, busy, level, bus.in_ready}, 6'b00_000_1);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) cyc();
        chk("t4_no_done", n_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
